if_id_fetch_queue: RTL

Fetch-side buffer between the program counter register and the decode stage of the pipelined RISC core. It takes the current PC, issues it to a synchronous instruction memory with 1-cycle read latency, and captures the returned word with its PC in a small FIFO. It presents instructions to decode over a valid/ready handshake. It generates pc_hold back to the PC input mux (credit-based flow control) and supports branch/jump flush.

---
 rtl/if_id_fetch_queue.sv | 92 +++++++++
 1 files changed

// File: rtl/if_id_fetch_queue.sv
// Fetch queue between the PC register and decode: issues PC to a 1-cycle synchronous
// instruction memory, captures {instr, pc} in a small FIFO, and throttles upstream via pc_hold.
module if_id_fetch_queue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          pc_count,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_rdata,
    output logic                       pc_hold,
    input  logic                       flush,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [DATA_W-1:0]          id_instr,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [ADDR_W-1:0]          id_pc_plus4,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              req_valid_q;
    logic [ADDR_W-1:0] req_pc_q;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    credit;

    assign imem_addr   = pc_count;
    assign id_instr    = instr_mem[rd_ptr];
    assign id_pc       = pc_mem[rd_ptr];
    assign id_pc_plus4 = id_pc + ADDR_W'(4);
    assign occupancy   = count;

    // Credits count buffered entries plus the in-flight request, minus the entry leaving
    // this cycle; the pop term keeps one instruction per cycle flowing at DEPTH=2.
    always_comb begin
        id_valid = (count != '0) && !flush;
        pop      = id_valid && id_ready;
        push     = req_valid_q && !flush;
        credit   = {1'b0, count} + (CNT_W+1)'(req_valid_q) - (CNT_W+1)'(pop);
        pc_hold  = (credit >= (CNT_W+1)'(DEPTH)) && !flush;
        issue    = !pc_hold && !flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem[PTR_W'(i)] <= '0;
                pc_mem[PTR_W'(i)]    <= '0;
            end
        end else begin
            req_pc_q <= pc_count;
            if (flush) begin
                count       <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                req_valid_q <= 1'b0;
            end else begin
                req_valid_q <= issue;
                if (push) begin
                    instr_mem[wr_ptr] <= imem_rdata;
                    pc_mem[wr_ptr]    <= req_pc_q;
                    wr_ptr            <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

endmodule
